// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set controller for the digital clock counter.
//
// Debounced button pulses walk the controller through an hours edit and
// then a minutes edit. Leaving the minutes edit with btn_mode produces a
// single-cycle o_normal_en load pulse. While that pulse is high, the digit
// outputs present the edited time to the counter. If no button is pressed
// for TIMEOUT_CYCLES cycles during an edit, the edit is abandoned without a
// load pulse.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   btn_mode/inc/dec      single-cycle button pulses (btn_mode has priority)
//   cur_hours/minutes     live counter time, seeds the edit on entry
//   o_hours_*/o_minutes_* decimal digits of the edited time (combinational)
//   o_normal_en           one-cycle load strobe to the counter
//   o_edit_field          00 none, 01 hours, 10 minutes
//   o_blink               blink enable for the field under edit
//   o_busy                high whenever not idle
module clock_set_ctrl #(
  parameter int TIMEOUT_CYCLES = 600,
  parameter int BLINK_HALF     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [1:0] o_hours_left,
  output logic [3:0] o_hours_right,
  output logic [2:0] o_minutes_left,
  output logic [3:0] o_minutes_right,
  output logic       o_normal_en,
  output logic [1:0] o_edit_field,
  output logic       o_blink,
  output logic       o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {IDLE, SET_H, SET_M, LOAD} state_t;

  state_t        state, state_n;
  logic [4:0]    edit_h, edit_h_n;
  logic [5:0]    edit_m, edit_m_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          blink, blink_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      edit_h <= '0;
      edit_m <= '0;
      tmo    <= '0;
      bcnt   <= '0;
      blink  <= 1'b0;
    end else begin
      state  <= state_n;
      edit_h <= edit_h_n;
      edit_m <= edit_m_n;
      tmo    <= tmo_n;
      bcnt   <= bcnt_n;
      blink  <= blink_n;
    end
  end

  // Counters and blink default to cleared. This covers state entry, any
  // button press and the non-edit states. Only a quiet edit cycle advances
  // them.
  always_comb begin
    state_n  = state;
    edit_h_n = edit_h;
    edit_m_n = edit_m;
    tmo_n    = '0;
    bcnt_n   = '0;
    blink_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_mode) begin
          state_n  = SET_H;
          // Out-of-range live values seed as zero rather than an invalid edit.
          edit_h_n = (cur_hours   > 5'd23) ? 5'd0 : cur_hours;
          edit_m_n = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
          blink_n  = 1'b1;
        end
      end
      SET_H, SET_M: begin
        if (btn_mode) begin
          if (state == SET_H) begin
            state_n = SET_M;
            blink_n = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end else if (btn_inc || btn_dec) begin
          // inc+dec together cancel but still count as activity.
          blink_n = 1'b1;
          if (btn_inc && !btn_dec) begin
            if (state == SET_H) edit_h_n = (edit_h == 5'd23) ? 5'd0 : edit_h + 5'd1;
            else                edit_m_n = (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
          end else if (btn_dec && !btn_inc) begin
            if (state == SET_H) edit_h_n = (edit_h == 5'd0) ? 5'd23 : edit_h - 5'd1;
            else                edit_m_n = (edit_m == 6'd0) ? 6'd59 : edit_m - 6'd1;
          end
        end else if (tmo == TMO_LAST) begin
          state_n = IDLE;  // abandon edit, keep edited values, no load
        end else begin
          tmo_n = tmo + TW'(1);
          if (bcnt == BCNT_LAST) begin
            blink_n = ~blink;
          end else begin
            bcnt_n  = bcnt + BW'(1);
            blink_n = blink;
          end
        end
      end
      LOAD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic [4:0] h_tens, h_units;
  logic [5:0] m_tens, m_units;

  always_comb begin
    h_tens  = edit_h / 5'd10;
    h_units = edit_h % 5'd10;
    m_tens  = edit_m / 6'd10;
    m_units = edit_m % 6'd10;
  end

  assign o_hours_left    = h_tens[1:0];
  assign o_hours_right   = h_units[3:0];
  assign o_minutes_left  = m_tens[2:0];
  assign o_minutes_right = m_units[3:0];

  // Decoded from state so that reset drops the strobe immediately.
  assign o_normal_en  = (state == LOAD);
  assign o_edit_field = (state == SET_H) ? 2'b01 : (state == SET_M) ? 2'b10 : 2'b00;
  assign o_blink      = blink;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;
  localparam int TMO = 600;
  localparam int BH  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [1:0] o_hours_left;
  logic [3:0] o_hours_right;
  logic [2:0] o_minutes_left;
  logic [3:0] o_minutes_right;
  logic       o_normal_en;
  logic [1:0] o_edit_field;
  logic       o_blink;
  logic       o_busy;

  clock_set_ctrl #(.TIMEOUT_CYCLES(TMO), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .o_hours_left(o_hours_left), .o_hours_right(o_hours_right),
    .o_minutes_left(o_minutes_left), .o_minutes_right(o_minutes_right),
    .o_normal_en(o_normal_en), .o_edit_field(o_edit_field),
    .o_blink(o_blink), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 hours edit, 2 minutes edit, 3 load.
  int m_st, m_h, m_m, m_idle, m_since;

  logic [17:0] act;
  assign act = {o_hours_left, o_hours_right, o_minutes_left, o_minutes_right,
                o_normal_en, o_edit_field, o_blink, o_busy};

  function automatic logic [17:0] exp_vec();
    logic [1:0] hl; logic [3:0] hr; logic [2:0] ml; logic [3:0] mr;
    logic [1:0] fld; logic bl;
    hl  = 2'(m_h / 10);
    hr  = 4'(m_h % 10);
    ml  = 3'(m_m / 10);
    mr  = 4'(m_m % 10);
    fld = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
    bl  = (m_st == 1 || m_st == 2) ? (((m_since / BH) % 2) == 0) : 1'b0;
    return {hl, hr, ml, mr, (m_st == 3), fld, bl, (m_st != 0)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_idle = 0; m_since = 0;
  endtask

  task automatic model_step(input logic md, input logic inc, input logic dec);
    int d;
    case (m_st)
      0: if (md) begin
        m_st = 1;
        m_h = (cur_hours > 23) ? 0 : int'(cur_hours);
        m_m = (cur_minutes > 59) ? 0 : int'(cur_minutes);
        m_idle = 0; m_since = 0;
      end
      1, 2: begin
        if (md) begin
          if (m_st == 1) begin m_st = 2; m_idle = 0; m_since = 0; end
          else m_st = 3;
        end else if (inc || dec) begin
          d = (inc && !dec) ? 1 : (dec && !inc) ? -1 : 0;
          if (m_st == 1) m_h = (m_h + d + 24) % 24;
          else           m_m = (m_m + d + 60) % 60;
          m_idle = 0; m_since = 0;
        end else if (m_idle == TMO - 1) begin
          m_st = 0;
        end else begin
          m_idle++; m_since++;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  // Drive one cycle of buttons, advance the model at the edge, settle.
  task automatic step(input logic md, input logic inc, input logic dec);
    @(negedge clk);
    btn_mode = md; btn_inc = inc; btn_dec = dec;
    @(posedge clk);
    model_step(md, inc, dec);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== 18'd0) begin
      failures++; $display("FAIL reset_state: got %h exp %h", act, 18'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    cur_hours = 5'd13; cur_minutes = 6'd45;
    step(1, 0, 0);
    checks++;
    if (o_edit_field !== 2'b01 || act !== exp_vec()) begin
      failures++; $display("FAIL basic_enter_h: got %h exp %h", act, exp_vec());
    end
    repeat (3) step(0, 1, 0);
    step(1, 0, 0);
    checks++;
    if (o_edit_field !== 2'b10 || act !== exp_vec()) begin
      failures++; $display("FAIL basic_enter_m: got %h exp %h", act, exp_vec());
    end
    repeat (2) step(0, 0, 1);
    step(1, 0, 0);
    checks++;
    if ({o_hours_left, o_hours_right, o_minutes_left, o_minutes_right} !== {2'd1, 4'd6, 3'd4, 4'd3}
        || o_normal_en !== 1'b1 || act !== exp_vec()) begin
      failures++; $display("FAIL basic_load: got %h exp %h", act, exp_vec());
    end
    step(0, 0, 0);
    checks++;
    if (o_normal_en !== 1'b0 || o_busy !== 1'b0 || act !== exp_vec()) begin
      failures++; $display("FAIL basic_after_load: got %h exp %h", act, exp_vec());
    end
  endtask

  task automatic test_wrap();
    cur_hours = 5'd23; cur_minutes = 6'd59;
    step(1, 0, 0);
    step(0, 1, 0);
    checks++;
    if (o_hours_left !== 2'd0 || o_hours_right !== 4'd0 || act !== exp_vec()) begin
      failures++; $display("FAIL wrap_h_up: got %h exp %h", act, exp_vec());
    end
    step(1, 0, 0);
    step(0, 1, 0);
    checks++;
    if (o_minutes_left !== 3'd0 || o_minutes_right !== 4'd0 || act !== exp_vec()) begin
      failures++; $display("FAIL wrap_m_up: got %h exp %h", act, exp_vec());
    end
    step(1, 0, 0);
    step(0, 0, 0);
    cur_hours = 5'd0; cur_minutes = 6'd0;
    step(1, 0, 0);
    step(0, 0, 1);
    checks++;
    if (o_hours_left !== 2'd2 || o_hours_right !== 4'd3 || act !== exp_vec()) begin
      failures++; $display("FAIL wrap_h_down: got %h exp %h", act, exp_vec());
    end
    step(1, 0, 0);
    step(0, 0, 1);
    checks++;
    if (o_minutes_left !== 3'd5 || o_minutes_right !== 4'd9 || act !== exp_vec()) begin
      failures++; $display("FAIL wrap_m_down: got %h exp %h", act, exp_vec());
    end
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic test_timeout();
    logic seen_ne;
    logic ok;
    cur_hours = 5'd7; cur_minutes = 6'd21;
    step(1, 0, 0);
    step(1, 0, 0);
    seen_ne = 1'b0; ok = 1'b1;
    for (int i = 0; i < TMO - 1; i++) begin
      step(0, 0, 0);
      if (o_normal_en) seen_ne = 1'b1;
      if (act !== exp_vec() || o_busy !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL timeout_hold: got %h exp %h", act, exp_vec());
    end
    step(0, 0, 0);
    if (o_normal_en) seen_ne = 1'b1;
    checks++;
    if (o_busy !== 1'b0 || seen_ne !== 1'b0 || act !== exp_vec()
        || o_minutes_left !== 3'd2 || o_minutes_right !== 4'd1) begin
      failures++; $display("FAIL timeout_exit: got busy=%b ne_seen=%b vec=%h exp %h", o_busy, seen_ne, act, exp_vec());
    end
    // A button in the terminal cycle beats the timeout.
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0);
    step(0, 1, 0);
    checks++;
    if (o_edit_field !== 2'b10 || o_minutes_right !== 4'd2 || act !== exp_vec()) begin
      failures++; $display("FAIL timeout_rescue: got %h exp %h", act, exp_vec());
    end
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic test_simultaneous();
    cur_hours = 5'd10; cur_minutes = 6'd30;
    step(1, 0, 0);
    step(1, 1, 0);
    checks++;
    if (o_edit_field !== 2'b10 || o_hours_left !== 2'd1 || o_hours_right !== 4'd0 || act !== exp_vec()) begin
      failures++; $display("FAIL simul_mode_inc: got %h exp %h", act, exp_vec());
    end
    step(0, 1, 1);
    checks++;
    if (o_minutes_left !== 3'd3 || o_minutes_right !== 4'd0 || act !== exp_vec()) begin
      failures++; $display("FAIL simul_inc_dec: got %h exp %h", act, exp_vec());
    end
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    cur_hours = 5'd12; cur_minutes = 6'd34;
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    checks++;
    if (o_normal_en !== 1'b1 || act !== exp_vec()) begin
      failures++; $display("FAIL rstmid_load: got %h exp %h", act, exp_vec());
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (act !== 18'd0) begin
      failures++; $display("FAIL rstmid_async: got %h exp %h", act, 18'd0);
    end
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_blink();
    logic ok;
    cur_hours = 5'd5; cur_minutes = 6'd5;
    step(1, 0, 0);
    checks++;
    if (o_blink !== 1'b1) begin
      failures++; $display("FAIL blink_entry: got %b exp 1", o_blink);
    end
    ok = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      step(0, 0, 0);
      if (act !== exp_vec()) ok = 1'b0;
      if (i == 29 && o_blink !== 1'b1) ok = 1'b0;
      if (i == 30 && o_blink !== 1'b0) ok = 1'b0;
      if (i == 60 && o_blink !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL blink_toggle: got %h exp %h", act, exp_vec());
    end
    repeat (2) step(0, 0, 0);  // since=67: phase 0 again, move to a low phase
    for (int i = 0; i < 25; i++) step(0, 0, 0);
    checks++;
    if (o_blink !== 1'b0) begin
      failures++; $display("FAIL blink_low_phase: got %b exp 0", o_blink);
    end
    step(0, 1, 0);
    checks++;
    if (o_blink !== 1'b1 || act !== exp_vec()) begin
      failures++; $display("FAIL blink_force: got %h exp %h", act, exp_vec());
    end
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    checks++;
    if (o_blink !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL blink_idle: got blink=%b busy=%b exp 0 0", o_blink, o_busy);
    end
  endtask

  task automatic test_random();
    int errs;
    logic md, inc, dec;
    errs = 0;
    for (int i = 0; i < 1500; i++) begin
      cur_hours   = 5'($urandom_range(0, 31));
      cur_minutes = 6'($urandom_range(0, 63));
      md  = ($urandom_range(0, 11) == 0);
      inc = ($urandom_range(0, 3) == 0);
      dec = ($urandom_range(0, 3) == 0);
      step(md, inc, dec);
      checks++;
      if (act !== exp_vec()) begin
        failures++; errs++;
        if (errs <= 5) $display("FAIL random_step %0d: got %h exp %h", i, act, exp_vec());
      end
    end
    step(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
